// File: rtl/oc8051_ram_bist_ctrl.sv
// oc8051_ram_bist_ctrl
// March C- self-test controller for the oc8051 internal data RAM. When a run
// is not in progress, the RAM ports pass straight through to the CPU. During
// a run, the controller owns the RAM and the CPU request inputs are ignored.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   bist_start          one-cycle request to begin a run (ignored while busy)
//   bist_busy/done      run in progress / run finished (held until next start)
//   bist_fail           sticky mismatch flag for the last run
//   bist_fail_addr/elem address and March element of the first mismatch
//   cpu_*               functional RAM requests; cpu_rd_data mirrors ram_rd_data
//   ram_*               RAM port; ram_rd_data is registered, one cycle after ram_rd_en
//
// Build option
//   OC8051_BIST_STOP_ON_FAIL_EN  when defined, the first mismatch ends the run
//                                on the next edge instead of completing it.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | after reset, RAM passed through to CPU
// RUN   | March C- in progress, controller owns the RAM
// DONE  | run finished, results held, RAM passed through
module oc8051_ram_bist_ctrl #(
   parameter int          ADDR_W = 8,
   parameter logic [7:0]  BG     = 8'h00
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bist_start,
   output logic              bist_busy,
   output logic              bist_done,
   output logic              bist_fail,
   output logic [ADDR_W-1:0] bist_fail_addr,
   output logic [2:0]        bist_fail_elem,
   input  logic [ADDR_W-1:0] cpu_rd_addr,
   input  logic              cpu_rd_en,
   input  logic [ADDR_W-1:0] cpu_wr_addr,
   input  logic [7:0]        cpu_wr_data,
   input  logic              cpu_wr,
   output logic [7:0]        cpu_rd_data,
   output logic [ADDR_W-1:0] ram_rd_addr,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_wr_addr,
   output logic [7:0]        ram_wr_data,
   output logic              ram_wr,
   input  logic [7:0]        ram_rd_data
);

   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr;
   logic [2:0]        elem;
   logic              phase;

   logic              two_phase, elem_down, step, addr_last, elem_end, run_end;
   logic              cmp, mismatch;
   logic [7:0]        exp_data, wr_val;

   // Element decode: M0 w0 | M1 r0,w1 | M2 r1,w0 | M3 r0,w1 (down) | M4 r1,w0 (down) | M5 r0
   always_comb begin
      two_phase = (elem != 3'd0);
      elem_down = (elem == 3'd3) || (elem == 3'd4);
      exp_data  = ((elem == 3'd2) || (elem == 3'd4)) ? ~BG : BG;
      wr_val    = ((elem == 3'd1) || (elem == 3'd3)) ? ~BG : BG;
      // the address moves on the last cycle spent on it
      step      = !two_phase || phase;
      addr_last = elem_down ? (addr == '0) : (addr == ADDR_MAX);
      elem_end  = step && addr_last;
      run_end   = elem_end && (elem == 3'd5);
      // read data for the R phase is valid in the following W/C phase
      cmp       = (state == S_RUN) && two_phase && phase;
      mismatch  = cmp && (ram_rd_data != exp_data);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (bist_start) state_nxt = S_RUN;
         S_RUN: begin
            if (run_end) state_nxt = S_DONE;
`ifdef OC8051_BIST_STOP_ON_FAIL_EN
            if (mismatch) state_nxt = S_DONE;
`endif
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr           <= '0;
         elem           <= 3'd0;
         phase          <= 1'b0;
         bist_fail      <= 1'b0;
         bist_fail_addr <= '0;
         bist_fail_elem <= 3'd0;
      end else if (state != S_RUN) begin
         if (bist_start) begin
            addr           <= '0;
            elem           <= 3'd0;
            phase          <= 1'b0;
            bist_fail      <= 1'b0;
            bist_fail_addr <= '0;
            bist_fail_elem <= 3'd0;
         end
      end else begin
         if (two_phase) phase <= ~phase;
         if (step) begin
            if (addr_last) begin
               if (elem != 3'd5) elem <= elem + 3'd1;
               // M3 and M4 walk downward and start from the top address
               addr <= ((elem == 3'd2) || (elem == 3'd3)) ? ADDR_MAX : '0;
            end else begin
               addr <= elem_down ? addr - 1'b1 : addr + 1'b1;
            end
         end
         if (mismatch && !bist_fail) begin
            bist_fail      <= 1'b1;
            bist_fail_addr <= addr;
            bist_fail_elem <= elem;
         end
      end
   end

   always_comb begin
      bist_busy   = (state == S_RUN);
      bist_done   = (state == S_DONE);
      cpu_rd_data = ram_rd_data;
      ram_rd_addr = cpu_rd_addr;
      ram_rd_en   = cpu_rd_en;
      ram_wr_addr = cpu_wr_addr;
      ram_wr_data = cpu_wr_data;
      ram_wr      = cpu_wr;
      if (state == S_RUN) begin
         // same address on both ports keeps the RAM write-through bypass idle
         ram_rd_addr = addr;
         ram_wr_addr = addr;
         ram_wr_data = wr_val;
         ram_rd_en   = two_phase && !phase;
         ram_wr      = (elem == 3'd0) || ((elem != 3'd5) && phase);
      end
   end

endmodule

// File: tb/tb_oc8051_ram_bist_ctrl.sv
module tb_oc8051_ram_bist_ctrl;
   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              bist_start = 1'b0;
   logic              bist_busy, bist_done, bist_fail;
   logic [ADDR_W-1:0] bist_fail_addr;
   logic [2:0]        bist_fail_elem;
   logic [ADDR_W-1:0] cpu_rd_addr = '0;
   logic              cpu_rd_en = 1'b0;
   logic [ADDR_W-1:0] cpu_wr_addr = '0;
   logic [7:0]        cpu_wr_data = 8'h00;
   logic              cpu_wr = 1'b0;
   logic [7:0]        cpu_rd_data;
   logic [ADDR_W-1:0] ram_rd_addr, ram_wr_addr;
   logic              ram_rd_en, ram_wr;
   logic [7:0]        ram_wr_data;
   logic [7:0]        ram_rd_data = 8'h00;

   oc8051_ram_bist_ctrl #(.ADDR_W(ADDR_W), .BG(8'h00)) dut (
      .clk(clk), .rst(rst), .bist_start(bist_start),
      .bist_busy(bist_busy), .bist_done(bist_done), .bist_fail(bist_fail),
      .bist_fail_addr(bist_fail_addr), .bist_fail_elem(bist_fail_elem),
      .cpu_rd_addr(cpu_rd_addr), .cpu_rd_en(cpu_rd_en), .cpu_wr_addr(cpu_wr_addr),
      .cpu_wr_data(cpu_wr_data), .cpu_wr(cpu_wr), .cpu_rd_data(cpu_rd_data),
      .ram_rd_addr(ram_rd_addr), .ram_rd_en(ram_rd_en), .ram_wr_addr(ram_wr_addr),
      .ram_wr_data(ram_wr_data), .ram_wr(ram_wr), .ram_rd_data(ram_rd_data)
   );

   always #5 clk = ~clk;

   // RAM model with registered read; optional stuck-at-1 on bit 3 of 8'h5A
   logic [7:0] mem [0:255];
   logic       fault_en = 1'b0;
   always @(posedge clk) begin
      if (ram_rd_en)
         ram_rd_data <= mem[ram_rd_addr] | ((fault_en && ram_rd_addr == 8'h5A) ? 8'h08 : 8'h00);
      if (ram_wr) mem[ram_wr_addr] <= ram_wr_data;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   int cyc, n_wr, n_rd, n_addr_diff;

   task automatic run_bist(input bit probe, input int restart_at, input int rst_at);
      @(negedge clk); bist_start = 1'b1;
      @(negedge clk); bist_start = 1'b0;
      cyc = 0; n_wr = 0; n_rd = 0; n_addr_diff = 0;
      while (bist_busy && cyc < 5000 && cyc != rst_at) begin
         if (ram_wr) n_wr++;
         if (ram_rd_en) n_rd++;
         if (ram_rd_addr != ram_wr_addr) n_addr_diff++;
         if (probe) begin
            if (cyc == 0) begin
               check("k0_wr", ram_wr, 1);
               check("k0_rd_en", ram_rd_en, 0);
               check("k0_addr", ram_wr_addr, 8'h00);
               check("k0_data", ram_wr_data, 8'h00);
               check("k0_fail_clr", bist_fail, 0);
            end
            if (cyc == 257) begin
               check("m1w_data", ram_wr_data, 8'hFF);
               check("m1w_addr", ram_wr_addr, 8'h00);
            end
            if (cyc == 1280) begin
               check("m3_start_addr", ram_rd_addr, 8'hFF);
               check("m3_start_rd", ram_rd_en, 1);
            end
            if (cyc == 1281) check("m3w_data", ram_wr_data, 8'hFF);
            if (cyc == 2304) check("m5_start_addr", ram_rd_addr, 8'h00);
            if (cyc == 2815) begin
               check("m5c_rd_en", ram_rd_en, 0);
               check("m5c_wr", ram_wr, 0);
               check("m5c_addr", ram_rd_addr, 8'hFF);
            end
         end
         bist_start = (cyc == restart_at);
         cyc++;
         @(negedge clk);
      end
      bist_start = 1'b0;
      if (rst_at < 0) check("run_bounded", cyc < 5000, 1);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      repeat (2) @(negedge clk);
      check("rst_busy", bist_busy, 0);
      check("rst_done", bist_done, 0);
      check("rst_fail", bist_fail, 0);
      check("rst_faddr", bist_fail_addr, 0);
      check("rst_felem", bist_fail_elem, 0);
      rst = 1'b1;
      @(negedge clk);

      // pass-through in IDLE
      cpu_rd_en = 1'b1; cpu_rd_addr = 8'h20; #1;
      check("pt_rd_en", ram_rd_en, 1);
      check("pt_rd_addr", ram_rd_addr, 8'h20);
      cpu_wr = 1'b1; cpu_wr_addr = 8'h10; cpu_wr_data = 8'hA5; #1;
      check("pt_wr", ram_wr, 1);
      check("pt_wr_addr", ram_wr_addr, 8'h10);
      check("pt_wr_data", ram_wr_data, 8'hA5);
      @(negedge clk);
      cpu_wr = 1'b0; cpu_rd_addr = 8'h10;
      @(negedge clk);
      check("pt_rd_data_a5", cpu_rd_data, 8'hA5);
      cpu_rd_addr = 8'h20;
      @(negedge clk);
      check("pt_rd_data_00", cpu_rd_data, 8'h00);
      cpu_rd_en = 1'b0;

      // fault-free run; CPU write held active and a start pulse mid-run
      cpu_wr = 1'b1; cpu_wr_addr = 8'h33; cpu_wr_data = 8'hFF;
      run_bist(1'b1, 500, -1);
      cpu_wr = 1'b0;
      check("r1_cycles", cyc, 2816);
      check("r1_writes", n_wr, 1280);
      check("r1_reads", n_rd, 1280);
      check("r1_addr_eq", n_addr_diff, 0);
      check("r1_done", bist_done, 1);
      check("r1_busy", bist_busy, 0);
      check("r1_fail", bist_fail, 0);

      // stuck-at fault, started from DONE
      fault_en = 1'b1;
      run_bist(1'b0, -1, -1);
`ifdef OC8051_BIST_STOP_ON_FAIL_EN
      check("r2_cycles", cyc, 438);
      check("r2_writes", n_wr, 347);
      n_wr = 0;
      repeat (5) begin
         if (ram_wr) n_wr++;
         @(negedge clk);
      end
      check("r2_no_wr_after", n_wr, 0);
`else
      check("r2_cycles", cyc, 2816);
`endif
      check("r2_done", bist_done, 1);
      check("r2_fail", bist_fail, 1);
      check("r2_faddr", bist_fail_addr, 8'h5A);
      check("r2_felem", bist_fail_elem, 1);

      // clean run from DONE clears previous results
      fault_en = 1'b0;
      run_bist(1'b1, -1, -1);
      check("r3_cycles", cyc, 2816);
      check("r3_done", bist_done, 1);
      check("r3_fail", bist_fail, 0);
      check("r3_faddr", bist_fail_addr, 0);

      // reset at cycle 1000 of a run
`ifndef OC8051_BIST_STOP_ON_FAIL_EN
      fault_en = 1'b1;
`endif
      run_bist(1'b0, -1, 1000);
      check("r4_reached", cyc, 1000);
      rst = 1'b0; #1;
      check("r4_busy", bist_busy, 0);
      check("r4_done", bist_done, 0);
      check("r4_fail", bist_fail, 0);
      check("r4_faddr", bist_fail_addr, 0);
      check("r4_felem", bist_fail_elem, 0);
      cpu_wr = 1'b1; cpu_wr_addr = 8'h10; cpu_wr_data = 8'h5C; #1;
      check("r4_pt_wr", ram_wr, 1);
      check("r4_pt_wr_addr", ram_wr_addr, 8'h10);
      check("r4_pt_wr_data", ram_wr_data, 8'h5C);
      @(negedge clk);
      cpu_wr = 1'b0; fault_en = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("r4_idle_done", bist_done, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
